// File: rtl/jacob_z_inverse.sv
// Sequential modular inverter: inv = a^-1 mod p by binary extended Euclid, one step per clock.
// Optional step-count watchdog enabled by defining INV_TIMEOUT_EN.
module jacob_z_inverse #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] p,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] inv
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] u, v, x1, x2, pm;
  logic             illegal, u_one, v_one, no_inv, timeout, term;

  // (x / 2) mod m for odd m; the add is carried at WIDTH+1 bits so nothing is lost before the shift.
  function automatic logic [WIDTH-1:0] mod_half(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
    return s[WIDTH:1];
  endfunction

  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] m);
    logic [WIDTH:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[WIDTH]) d = d + {1'b0, m};
    return d[WIDTH-1:0];
  endfunction

  assign illegal = (a == '0) || (a >= p) || !p[0];
  assign u_one   = (u == WIDTH'(1));
  assign v_one   = (v == WIDTH'(1));
  assign no_inv  = (u == '0) || (v == '0);
  assign term    = u_one || v_one || no_inv || timeout;

`ifdef INV_TIMEOUT_EN
  localparam int TMO_STEPS = 4*WIDTH + 2;
  localparam int CNT_W     = $clog2(4*WIDTH + 4);
  logic [CNT_W-1:0] step_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                       step_cnt <= '0;
    else if (state == IDLE && start) step_cnt <= '0;
    else if (state == RUN)           step_cnt <= step_cnt + CNT_W'(1);
  end

  assign timeout = (step_cnt == CNT_W'(TMO_STEPS));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = illegal ? DONE : RUN;
      RUN:     if (term)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Datapath: operand capture in IDLE, one prioritised Euclid step per RUN cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      u   <= '0;
      v   <= '0;
      x1  <= '0;
      x2  <= '0;
      pm  <= '0;
      err <= 1'b0;
      inv <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (illegal) begin
              err <= 1'b1;
              inv <= '0;
            end else begin
              u  <= a;
              v  <= p;
              x1 <= WIDTH'(1);
              x2 <= '0;
              pm <= p;
            end
          end
        end
        RUN: begin
          if (u_one) begin
            err <= 1'b0;
            inv <= x1;
          end else if (v_one) begin
            err <= 1'b0;
            inv <= x2;
          end else if (no_inv || timeout) begin
            err <= 1'b1;
            inv <= '0;
          end else if (!u[0]) begin
            u  <= u >> 1;
            x1 <= mod_half(x1, pm);
          end else if (!v[0]) begin
            v  <= v >> 1;
            x2 <= mod_half(x2, pm);
          end else if (u >= v) begin
            u  <= u - v;
            x1 <= mod_sub(x1, x2, pm);
          end else begin
            v  <= v - u;
            x2 <= mod_sub(x2, x1, pm);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
